// File: rtl/fir_filter_mac.sv
// Time-multiplexed signed FIR filter: one shared multiply-accumulate, TAPS cycles per sample,
// run-time writable coefficient file, round-half-up scaling and saturating output.
module fir_filter_mac #(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 8,
    parameter int TAPS      = 74,
    parameter int ACC_W     = 24,
    parameter int FRAC_BITS = 8,
    parameter int OUT_W     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATA_W-1:0]  in_data,
    input  logic                      coef_we,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]  coef_wdata,
    output logic                      busy,
    output logic                      out_valid,
    output logic signed [OUT_W-1:0]   out_data,
    output logic                      sat_flag
);

    localparam int K_W     = $clog2(TAPS);
    localparam int PROD_W  = DATA_W + COEF_W;
    localparam int ROUND_C = (FRAC_BITS > 0) ? (1 << (FRAC_BITS - 1)) : 0;
    localparam logic [K_W-1:0] LAST_K = K_W'(TAPS - 1);
    localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W + 1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] OUT_MIN = -OUT_MAX - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_DONE
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic signed [DATA_W-1:0] r_x [TAPS];
    // NOTE: the coefficient file has no reset so coefficients survive rst; only its power-up value is defined.
    logic signed [COEF_W-1:0] r_coef [TAPS] = '{default: '0};
    logic signed [ACC_W-1:0]  r_acc;
    logic [K_W-1:0]           r_k;
    logic                     r_out_valid;
    logic signed [OUT_W-1:0]  r_out_data;
    logic                     r_sat_flag;

    logic                     w_in_ready;
    logic                     w_accept;
    logic                     w_coef_wr;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W:0]    w_biased;
    logic signed [ACC_W:0]    w_r;

    assign w_in_ready = (r_state == S_IDLE) && !rst;
    assign w_accept   = in_valid && w_in_ready;
    // Writes are accepted only in IDLE so a sample in flight always sees one coefficient set.
    assign w_coef_wr  = coef_we && (r_state == S_IDLE) && ({1'b0, coef_addr} < (K_W + 1)'(TAPS));

    assign w_prod     = r_coef[r_k] * r_x[r_k];
    assign w_prod_ext = w_prod;
    assign w_biased   = r_acc + (ACC_W + 1)'(ROUND_C);
    assign w_r        = w_biased >>> FRAC_BITS;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_MAC;
            S_MAC:   if (r_k == LAST_K) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_k         <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_sat_flag  <= 1'b0;
            for (int i = 0; i < TAPS; i++) r_x[i] <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_x[0] <= in_data;
                        for (int i = 1; i < TAPS; i++) r_x[i] <= r_x[i-1];
                        r_acc <= '0;
                        r_k   <= '0;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_k   <= (r_k == LAST_K) ? '0 : r_k + 1'b1;
                end
                S_DONE: begin
                    r_out_valid <= 1'b1;
                    if (w_r > OUT_MAX) begin
                        r_out_data <= OUT_MAX[OUT_W-1:0];
                        r_sat_flag <= 1'b1;
                    end else if (w_r < OUT_MIN) begin
                        r_out_data <= OUT_MIN[OUT_W-1:0];
                        r_sat_flag <= 1'b1;
                    end else begin
                        r_out_data <= w_r[OUT_W-1:0];
                        r_sat_flag <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_coef_wr) r_coef[coef_addr] <= coef_wdata;
    end

    assign in_ready  = w_in_ready;
    assign busy      = !w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign sat_flag  = r_sat_flag;

endmodule

// File: tb/tb_fir_filter_mac.sv
// Self-checking bench: a 4-tap unscaled instance and a default 74-tap instance, each with a
// reference model feeding an expected-result queue that a monitor drains on every out_valid.
module tb_fir_filter_mac;

    typedef struct {
        int data;
        int sat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 4-tap instance, FRAC_BITS=0
    logic              rst_a, in_valid_a, in_ready_a, coef_we_a, busy_a, out_valid_a, sat_a;
    logic signed [7:0] in_data_a, coef_wdata_a, out_data_a;
    logic [1:0]        coef_addr_a;
    // default instance
    logic              rst_b, in_valid_b, in_ready_b, coef_we_b, busy_b, out_valid_b, sat_b;
    logic signed [7:0] in_data_b, coef_wdata_b, out_data_b;
    logic [6:0]        coef_addr_b;

    fir_filter_mac #(.DATA_W(8), .COEF_W(8), .TAPS(4), .ACC_W(24), .FRAC_BITS(0), .OUT_W(8)) dut_a (
        .clk(clk), .rst(rst_a), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
        .coef_we(coef_we_a), .coef_addr(coef_addr_a), .coef_wdata(coef_wdata_a), .busy(busy_a),
        .out_valid(out_valid_a), .out_data(out_data_a), .sat_flag(sat_a)
    );

    fir_filter_mac dut_b (
        .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .coef_we(coef_we_b), .coef_addr(coef_addr_b), .coef_wdata(coef_wdata_b), .busy(busy_b),
        .out_valid(out_valid_b), .out_data(out_data_b), .sat_flag(sat_b)
    );

    int   ma_x [4];
    int   ma_c [4];
    int   mb_x [74];
    int   mb_c [74];
    exp_t qa [$];
    exp_t qb [$];
    int   a_out_cyc [$];
    int   b_out_cnt = 0;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t scale(input longint acc, input int frac);
        exp_t   e;
        longint r;
        r = (frac > 0) ? ((acc + (longint'(1) <<< (frac - 1))) >>> frac) : acc;
        if (r > 127)       begin e.data = 127;    e.sat = 1; end
        else if (r < -128) begin e.data = -128;   e.sat = 1; end
        else               begin e.data = int'(r); e.sat = 0; end
        return e;
    endfunction

    always @(negedge clk) begin
        if (out_valid_a) begin
            exp_t e;
            a_out_cyc.push_back(cyc);
            if (qa.size() == 0) check("a_unexpected_out", int'(out_valid_a), 0);
            else begin
                e = qa.pop_front();
                check("a_data", out_data_a, e.data);
                check("a_sat", int'(sat_a), e.sat);
            end
        end
        if (out_valid_b) begin
            exp_t e;
            b_out_cnt++;
            if (qb.size() == 0) check("b_unexpected_out", int'(out_valid_b), 0);
            else begin
                e = qb.pop_front();
                check("b_data", out_data_b, e.data);
                check("b_sat", int'(sat_b), e.sat);
            end
        end
    end

    task automatic wr_a(input int addr, input int data, input bit take);
        @(negedge clk);
        coef_we_a = 1'b1; coef_addr_a = addr[1:0]; coef_wdata_a = data[7:0];
        @(posedge clk);
        if (take) ma_c[addr] = data;
        #1 coef_we_a = 1'b0;
    endtask

    task automatic wr_b(input int addr, input int data);
        @(negedge clk);
        coef_we_b = 1'b1; coef_addr_b = addr[6:0]; coef_wdata_b = data[7:0];
        @(posedge clk);
        mb_c[addr] = data;
        #1 coef_we_b = 1'b0;
    endtask

    // Leaves in_valid high after the accept edge; the next send or a drain updates it.
    task automatic send_a(input int v, input bit wr, input int waddr, input int wdata);
        longint acc;
        int     n;
        @(negedge clk);
        in_valid_a = 1'b1; in_data_a = v[7:0];
        n = 0;
        while (!in_ready_a && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("a_accept_timeout", int'(in_ready_a), 1);
        if (wr) begin coef_we_a = 1'b1; coef_addr_a = waddr[1:0]; coef_wdata_a = wdata[7:0]; end
        @(posedge clk);
        if (wr) ma_c[waddr] = wdata;
        for (int i = 3; i > 0; i--) ma_x[i] = ma_x[i-1];
        ma_x[0] = v;
        acc = 0;
        for (int i = 0; i < 4; i++) acc += longint'(ma_c[i]) * ma_x[i];
        qa.push_back(scale(acc, 0));
        #1 coef_we_a = 1'b0;
    endtask

    task automatic send_b(input int v);
        longint acc;
        int     n;
        @(negedge clk);
        in_valid_b = 1'b1; in_data_b = v[7:0];
        n = 0;
        while (!in_ready_b && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("b_accept_timeout", int'(in_ready_b), 1);
        @(posedge clk);
        for (int i = 73; i > 0; i--) mb_x[i] = mb_x[i-1];
        mb_x[0] = v;
        acc = 0;
        for (int i = 0; i < 74; i++) acc += longint'(mb_c[i]) * mb_x[i];
        qb.push_back(scale(acc, 8));
    endtask

    task automatic drain_a();
        int n;
        @(negedge clk);
        in_valid_a = 1'b0;
        n = 0;
        while (qa.size() != 0 && n < 2000) begin @(negedge clk); n++; end
        check("a_drain_pending", qa.size(), 0);
    endtask

    task automatic drain_b();
        int n;
        @(negedge clk);
        in_valid_b = 1'b0;
        n = 0;
        while (qb.size() != 0 && n < 2000) begin @(negedge clk); n++; end
        check("b_drain_pending", qb.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt_before;
        foreach (ma_x[i]) begin ma_x[i] = 0; ma_c[i] = 0; end
        foreach (mb_x[i]) begin mb_x[i] = 0; mb_c[i] = 0; end
        rst_a = 1'b1; in_valid_a = 1'b0; in_data_a = '0; coef_we_a = 1'b0; coef_addr_a = '0; coef_wdata_a = '0;
        rst_b = 1'b1; in_valid_b = 1'b0; in_data_b = '0; coef_we_b = 1'b0; coef_addr_b = '0; coef_wdata_b = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_a_out_valid", int'(out_valid_a), 0);
        check("rst_a_out_data", out_data_a, 0);
        check("rst_a_sat", int'(sat_a), 0);
        check("rst_a_in_ready_held", int'(in_ready_a), 0);
        check("rst_b_out_valid", int'(out_valid_b), 0);
        check("rst_b_out_data", out_data_b, 0);
        check("rst_b_busy_held", int'(busy_b), 1);
        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        check("rst_a_in_ready", int'(in_ready_a), 1);
        check("rst_a_busy", int'(busy_a), 0);
        check("rst_b_in_ready", int'(in_ready_b), 1);

        // Impulse on 4 taps, back-to-back, output spacing TAPS+2
        for (int k = 0; k < 4; k++) wr_a(k, k + 1, 1'b1);
        a_out_cyc.delete();
        send_a(1, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) send_a(0, 1'b0, 0, 0);
        drain_a();
        check("a_impulse_count", a_out_cyc.size(), 5);
        for (int i = 1; i < a_out_cyc.size(); i++)
            check("a_out_spacing", a_out_cyc[i] - a_out_cyc[i-1], 6);

        // Coefficient write while busy is ignored
        send_a(7, 1'b0, 0, 0);
        wr_a(1, 50, 1'b0);
        check("a_busy_mid", int'(busy_a), 1);
        check("a_ready_mid", int'(in_ready_a), 0);
        drain_a();
        send_a(1, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) send_a(0, 1'b0, 0, 0);
        drain_a();

        // Continuous in_valid with incrementing data
        for (int v = 10; v < 20; v++) send_a(v, 1'b0, 0, 0);
        drain_a();

        // Coefficient write and accept on the same IDLE edge
        wr_a(0, 5, 1'b1);
        for (int i = 0; i < 4; i++) send_a(0, 1'b0, 0, 0);
        drain_a();
        send_a(1, 1'b1, 0, 9);
        drain_a();
        check("a_simul_model", qa.size(), 0);

        // Rounding on default instance
        for (int k = 0; k < 74; k++) wr_b(k, (k == 0) ? 127 : 0);
        send_b(127);
        drain_b();
        wr_b(0, -128);
        send_b(1);
        send_b(-3);
        drain_b();

        // Saturation in both directions
        for (int k = 0; k < 74; k++) wr_b(k, 127);
        for (int i = 0; i < 74; i++) send_b(127);
        drain_b();
        for (int i = 0; i < 74; i++) send_b(-128);
        drain_b();

        // Reset during MAC abandons the sample and clears the delay line
        for (int k = 0; k < 8; k++) wr_b(k, ((k * 29) % 200) - 100);
        send_b(55);
        repeat (10) @(posedge clk);
        @(negedge clk);
        in_valid_b = 1'b0;
        rst_b = 1'b1;
        @(negedge clk);
        check("b_ready_in_rst", int'(in_ready_b), 0);
        rst_b = 1'b0;
        #1;
        check("b_ready_after_rst", int'(in_ready_b), 1);
        check("b_busy_after_rst", int'(busy_b), 0);
        void'(qb.pop_back());
        foreach (mb_x[i]) mb_x[i] = 0;
        cnt_before = b_out_cnt;
        repeat (90) @(negedge clk);
        check("b_no_out_after_rst", b_out_cnt - cnt_before, 0);
        send_b(100);
        for (int i = 0; i < 7; i++) send_b(0);
        drain_b();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
